fp_byte_sequencer: RTL

//  Byte-wide front-end for float_alu. Assembles a command byte and operand bytes into op_a/op_b.

---
 rtl/fp_byte_sequencer_pkg.sv | 44 ++++
 rtl/fp_byte_sequencer_shifter.sv | 31 +++
 rtl/fp_byte_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fp_byte_sequencer_pkg.sv
// Shared definitions for the byte-wide float_alu front-end: command byte
// field positions, ALU opcode and precision encodings, flag bit positions,
// the sequencer state encoding and small decode helpers.
package fp_byte_sequencer_pkg;

  // Command byte layout: [2:0] op_code, [3] mode_fp, [4] round_mode, [7:5] unused
  localparam int CMD_OP_LSB   = 0;
  localparam int CMD_MODE_BIT = 3;
  localparam int CMD_RND_BIT  = 4;

  // float_alu opcodes understood by the sequencer
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  // Precision selector carried in mode_fp
  localparam logic FP_SINGLE = 1'b1;
  localparam logic FP_HALF   = 1'b0;

  // float_alu flag bit positions
  localparam int F_INVALID   = 0;
  localparam int F_DIVZERO   = 1;
  localparam int F_OVERFLOW  = 2;
  localparam int F_UNDERFLOW = 3;
  localparam int F_INEXACT   = 4;
  localparam int F_COUNT     = 5;

  // Sequencer state encoding, also visible on the dbg_state port
  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD_A = 3'd1,
    SEQ_LOAD_B = 3'd2,
    SEQ_ISSUE  = 3'd3,
    SEQ_WAIT   = 3'd4,
    SEQ_SEND   = 3'd5
  } seq_state_e;

  // True for opcodes the sequencer is willing to launch
  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/fp_byte_sequencer_shifter.sv
// N-bit operand register written one byte at a time. The byte lane is picked
// by idx; clr zeroes the whole register so half-precision operands end up
// zero-extended above bit 15.
module fp_byte_shifter #(
  parameter int N  = 32,
  parameter int NB = N / 8,
  parameter int IW = $clog2(NB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    data,
  output logic [N-1:0]  q
);

  // Clear has priority over a byte write; only the addressed lane changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (idx == IW'(i)) q[i*8 +: 8] <= data;
      end
    end
  end

endmodule

// File: rtl/fp_byte_sequencer.sv
// Byte-wide front-end for float_alu. Collects a command byte and two
// little-endian operands, launches one ALU operation, captures result and
// flags, then streams the result bytes (LSB first) and a flags byte out.
//
// Handshakes: every byte port uses valid/ready; a transfer happens on the
// rising clock edge where both are high. The producer holds data and valid
// stable until the transfer; the consumer may drive ready freely.
module fp_byte_sequencer
  import fp_byte_sequencer_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   data_in,
  input  logic         data_in_valid,
  output logic         in_ready,
  output logic [7:0]   data_out,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic         busy,
  output logic         err,
  output logic [N-1:0] alu_op_a,
  output logic [N-1:0] alu_op_b,
  output logic [2:0]   alu_op_code,
  output logic         alu_mode_fp,
  output logic         alu_round_mode,
  output logic         alu_start,
  output logic         alu_ready_in,
  input  logic         alu_valid_out,
  input  logic         alu_ready_out,
  input  logic [N-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [2:0]   dbg_state
);

  localparam int NB = N / 8;
  localparam int IW = $clog2(NB);
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_SINGLE = CW'(NB - 1);
  localparam logic [CW-1:0] LAST_HALF   = CW'(1);

  seq_state_e state, next_state;

  logic [CW-1:0]    byte_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [2:0]       cmd_op;
  logic             cmd_mode;
  logic             cmd_rnd;
  logic [N-1:0]     result_q;
  logic [F_COUNT-1:0] flags_q;

  logic          in_accept;
  logic          out_accept;
  logic          cmd_ok;
  logic [CW-1:0] last_idx;
  logic [CW-1:0] nxt_idx;
  logic          at_last;
  logic          at_flags;
  logic          tmo_hit;
  logic [7:0]    nxt_byte;
  logic          clr_ops;
  logic          wr_a;
  logic          wr_b;

  assign in_accept  = data_in_valid && in_ready;
  assign out_accept = data_out_valid && data_out_ready;
  assign cmd_ok     = op_supported(data_in[CMD_OP_LSB +: 3]);
  assign last_idx   = (cmd_mode == FP_SINGLE) ? LAST_SINGLE : LAST_HALF;
  assign nxt_idx    = byte_cnt + 1'b1;
  assign at_last    = (byte_cnt == last_idx);
  assign at_flags   = (byte_cnt == last_idx + 1'b1);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
  assign nxt_byte   = 8'(result_q >> {nxt_idx[IW-1:0], 3'b000});

  assign clr_ops = (state == SEQ_IDLE) && in_accept && cmd_ok;
  assign wr_a    = (state == SEQ_LOAD_A) && in_accept;
  assign wr_b    = (state == SEQ_LOAD_B) && in_accept;

  fp_byte_shifter #(.N(N)) u_op_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_ops),
    .wr_en (wr_a),
    .idx   (byte_cnt[IW-1:0]),
    .data  (data_in),
    .q     (alu_op_a)
  );

  fp_byte_shifter #(.N(N)) u_op_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_ops),
    .wr_en (wr_b),
    .idx   (byte_cnt[IW-1:0]),
    .data  (data_in),
    .q     (alu_op_b)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= next_state;
  end

  // Next-state decode; a result arriving on the timeout cycle is still taken
  always_comb begin
    next_state = state;
    unique case (state)
      SEQ_IDLE:   if (in_accept && cmd_ok)    next_state = SEQ_LOAD_A;
      SEQ_LOAD_A: if (in_accept && at_last)   next_state = SEQ_LOAD_B;
      SEQ_LOAD_B: if (in_accept && at_last)   next_state = SEQ_ISSUE;
      SEQ_ISSUE:  if (alu_ready_out)          next_state = SEQ_WAIT;
      SEQ_WAIT: begin
        if (alu_valid_out)  next_state = SEQ_SEND;
        else if (tmo_hit)   next_state = SEQ_IDLE;
      end
      SEQ_SEND:   if (out_accept && at_flags) next_state = SEQ_IDLE;
      default:    next_state = SEQ_IDLE;
    endcase
  end

  // Outputs decoded straight from state
  always_comb begin
    in_ready       = (state == SEQ_IDLE) || (state == SEQ_LOAD_A) || (state == SEQ_LOAD_B);
    busy           = (state != SEQ_IDLE);
    alu_start      = (state == SEQ_ISSUE) && alu_ready_out;
    alu_ready_in   = (state == SEQ_WAIT);
    data_out_valid = (state == SEQ_SEND);
    dbg_state      = state;
  end

  // Command latch, byte/timeout counters, result capture and output byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      cmd_op   <= '0;
      cmd_mode <= 1'b0;
      cmd_rnd  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        SEQ_IDLE: begin
          if (in_accept) begin
            cmd_op   <= data_in[CMD_OP_LSB +: 3];
            cmd_mode <= data_in[CMD_MODE_BIT];
            cmd_rnd  <= data_in[CMD_RND_BIT];
            byte_cnt <= '0;
            if (!cmd_ok) err <= 1'b1;
          end
        end
        SEQ_LOAD_A: begin
          if (in_accept) byte_cnt <= at_last ? '0 : nxt_idx;
        end
        SEQ_LOAD_B: begin
          if (in_accept) byte_cnt <= nxt_idx;
        end
        SEQ_ISSUE: begin
          if (alu_ready_out) tmo_cnt <= '0;
        end
        SEQ_WAIT: begin
          if (alu_valid_out) begin
            result_q <= alu_result;
            flags_q  <= alu_flags;
            data_out <= alu_result[7:0];
            byte_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err <= 1'b1;
          end
        end
        SEQ_SEND: begin
          if (out_accept) begin
            byte_cnt <= nxt_idx;
            if (at_flags)     data_out <= '0;
            else if (at_last) data_out <= {3'b000, flags_q};
            else              data_out <= nxt_byte;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_op_code    = cmd_op;
  assign alu_mode_fp    = cmd_mode;
  assign alu_round_mode = cmd_rnd;

endmodule
